// File: rtl/pipeline_hazard_controller.sv
// Stall/flush controller for the 5-stage core: load-use, redirect and
// data-RAM wait handling with a memory watchdog and event counters.
module pipeline_hazard_controller #(
  parameter int MEM_TIMEOUT = 16,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [4:0]             id_rs1_address,
  input  logic [4:0]             id_rs2_address,
  input  logic                   id_rs1_used,
  input  logic                   id_rs2_used,
  input  logic [4:0]             ex_rd_address,
  input  logic                   ex_reg_wren,
  input  logic                   ex_reg_write_data_src,
  input  logic                   ex_next_pc_src,
  input  logic                   mem_req,
  input  logic                   mem_ready,
  output logic                   pc_wren,
  output logic                   if_id_wren,
  output logic                   if_id_flush,
  output logic                   id_ex_wren,
  output logic                   id_ex_bubble,
  output logic                   mem_error,
  output logic [COUNT_WIDTH-1:0] stall_count,
  output logic [COUNT_WIDTH-1:0] bubble_count,
  output logic [COUNT_WIDTH-1:0] flush_count
);

  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WW-1:0] WLAST = WW'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [WW-1:0]          wait_q, wait_d;
  logic [COUNT_WIDTH-1:0] stall_q, stall_d;
  logic [COUNT_WIDTH-1:0] bubble_q, bubble_d;
  logic [COUNT_WIDTH-1:0] flush_q, flush_d;

  logic mem_stall;
  logic redirect;
  logic load_use;
  logic rs1_hit;
  logic rs2_hit;
  logic active;

  function automatic logic [COUNT_WIDTH-1:0] sat_inc(
    input logic [COUNT_WIDTH-1:0] v
  );
    return (&v) ? v : v + COUNT_WIDTH'(1);
  endfunction

  assign mem_stall = mem_req && !mem_ready;
  assign redirect  = ex_next_pc_src;
  assign rs1_hit   = id_rs1_used && (id_rs1_address == ex_rd_address);
  assign rs2_hit   = id_rs2_used && (id_rs2_address == ex_rd_address);
  assign load_use  = ex_reg_wren && ex_reg_write_data_src &&
                     (ex_rd_address != 5'd0) && (rs1_hit || rs2_hit);
  assign active    = !reset && (state_q != ERROR);

  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    stall_d      = stall_q;
    bubble_d     = bubble_q;
    flush_d      = flush_q;
    pc_wren      = 1'b0;
    if_id_wren   = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_wren   = 1'b0;
    id_ex_bubble = 1'b0;
    if (active) begin
      if (mem_stall) begin
        stall_d = sat_inc(stall_q);
        if (wait_q == WLAST) begin
          state_d = ERROR;
        end else begin
          state_d = MEM_WAIT;
          wait_d  = wait_q + WW'(1);
        end
      end else begin
        state_d = RUN;
        wait_d  = '0;
        if (redirect) begin
          pc_wren      = 1'b1;
          if_id_wren   = 1'b1;
          if_id_flush  = 1'b1;
          id_ex_wren   = 1'b1;
          id_ex_bubble = 1'b1;
          flush_d      = sat_inc(flush_q);
        end else if (load_use) begin
          id_ex_wren   = 1'b1;
          id_ex_bubble = 1'b1;
          bubble_d     = sat_inc(bubble_q);
        end else begin
          pc_wren      = 1'b1;
          if_id_wren   = 1'b1;
          id_ex_wren   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= RUN;
      wait_q   <= '0;
      stall_q  <= '0;
      bubble_q <= '0;
      flush_q  <= '0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      stall_q  <= stall_d;
      bubble_q <= bubble_d;
      flush_q  <= flush_d;
    end
  end

  assign mem_error    = (state_q == ERROR);
  assign stall_count  = stall_q;
  assign bubble_count = bubble_q;
  assign flush_count  = flush_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Scoreboard bench: two controller instances (different timeout/width)
// share stimulus and are checked against a behavioural model.
module tb_pipeline_hazard_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rs1, rs2, exrd;
  logic       u1, u2, exw, exsrc, redir, mreq, mrdy;

  logic       a_pc, a_ifid, a_fl, a_idex, a_bub, a_me;
  logic [7:0] a_sc, a_bc, a_fc;
  logic       b_pc, b_ifid, b_fl, b_idex, b_bub, b_me;
  logic [1:0] b_sc, b_bc, b_fc;

  always #5 clk = ~clk;

  pipeline_hazard_controller #(.MEM_TIMEOUT(6), .COUNT_WIDTH(8)) u_a (
    .clk(clk), .reset(reset),
    .id_rs1_address(rs1), .id_rs2_address(rs2),
    .id_rs1_used(u1), .id_rs2_used(u2),
    .ex_rd_address(exrd), .ex_reg_wren(exw),
    .ex_reg_write_data_src(exsrc), .ex_next_pc_src(redir),
    .mem_req(mreq), .mem_ready(mrdy),
    .pc_wren(a_pc), .if_id_wren(a_ifid), .if_id_flush(a_fl),
    .id_ex_wren(a_idex), .id_ex_bubble(a_bub), .mem_error(a_me),
    .stall_count(a_sc), .bubble_count(a_bc), .flush_count(a_fc)
  );

  pipeline_hazard_controller #(.MEM_TIMEOUT(4), .COUNT_WIDTH(2)) u_b (
    .clk(clk), .reset(reset),
    .id_rs1_address(rs1), .id_rs2_address(rs2),
    .id_rs1_used(u1), .id_rs2_used(u2),
    .ex_rd_address(exrd), .ex_reg_wren(exw),
    .ex_reg_write_data_src(exsrc), .ex_next_pc_src(redir),
    .mem_req(mreq), .mem_ready(mrdy),
    .pc_wren(b_pc), .if_id_wren(b_ifid), .if_id_flush(b_fl),
    .id_ex_wren(b_idex), .id_ex_bubble(b_bub), .mem_error(b_me),
    .stall_count(b_sc), .bubble_count(b_bc), .flush_count(b_fc)
  );

  typedef struct {
    bit     pc, ifid, fl, idex, bub, me;
    longint sc, bc, fc;
  } exp_t;

  exp_t   q0[$];
  exp_t   q1[$];
  int     checks = 0;
  int     failures = 0;

  int     tmo[2]  = '{6, 4};
  longint cmax[2] = '{255, 3};
  int     streak[2];
  bit     err[2];
  longint sc[2], bc[2], fc[2];

  // Model: a frozen cycle counts toward a run of consecutive stalls; once
  // the run reaches the timeout the unit is dead until reset.
  task automatic model(input int d);
    exp_t e;
    bit stall, lu;
    stall = mreq && !mrdy;
    lu = exw && exsrc && (exrd != 0) &&
         ((u1 && rs1 == exrd) || (u2 && rs2 == exrd));
    e = '{pc: 0, ifid: 0, fl: 0, idex: 0, bub: 0, me: err[d],
          sc: sc[d], bc: bc[d], fc: fc[d]};
    if (!reset && !err[d] && !stall) begin
      if (redir) e = '{pc: 1, ifid: 1, fl: 1, idex: 1, bub: 1, me: 0,
                       sc: sc[d], bc: bc[d], fc: fc[d]};
      else if (lu) begin e.idex = 1; e.bub = 1; end
      else begin e.pc = 1; e.ifid = 1; e.idex = 1; end
    end
    if (d == 0) q0.push_back(e); else q1.push_back(e);
    if (reset) begin
      err[d] = 0; streak[d] = 0; sc[d] = 0; bc[d] = 0; fc[d] = 0;
    end else if (!err[d]) begin
      if (stall) begin
        sc[d] = (sc[d] < cmax[d]) ? sc[d] + 1 : sc[d];
        streak[d]++;
        if (streak[d] >= tmo[d]) err[d] = 1;
      end else begin
        streak[d] = 0;
        if (redir) fc[d] = (fc[d] < cmax[d]) ? fc[d] + 1 : fc[d];
        else if (lu) bc[d] = (bc[d] < cmax[d]) ? bc[d] + 1 : bc[d];
      end
    end
  endtask

  task automatic drive(input bit rst, input logic [4:0] r1, r2,
                       input bit v1, v2, input logic [4:0] rd,
                       input bit w, src, rdr, mq, mr);
    @(posedge clk);
    #1;
    reset = rst; rs1 = r1; rs2 = r2; u1 = v1; u2 = v2;
    exrd = rd; exw = w; exsrc = src; redir = rdr;
    mreq = mq; mrdy = mr;
    model(0);
    model(1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic chk(input string n, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d @%0t", n, act, req, $time);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q0.size() > 0) begin
        e = q0.pop_front();
        chk("a.pc_wren", 64'(a_pc), 64'(e.pc));
        chk("a.if_id_wren", 64'(a_ifid), 64'(e.ifid));
        chk("a.if_id_flush", 64'(a_fl), 64'(e.fl));
        chk("a.id_ex_wren", 64'(a_idex), 64'(e.idex));
        chk("a.id_ex_bubble", 64'(a_bub), 64'(e.bub));
        chk("a.mem_error", 64'(a_me), 64'(e.me));
        chk("a.stall_count", 64'(a_sc), e.sc);
        chk("a.bubble_count", 64'(a_bc), e.bc);
        chk("a.flush_count", 64'(a_fc), e.fc);
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        chk("b.pc_wren", 64'(b_pc), 64'(e.pc));
        chk("b.if_id_wren", 64'(b_ifid), 64'(e.ifid));
        chk("b.if_id_flush", 64'(b_fl), 64'(e.fl));
        chk("b.id_ex_wren", 64'(b_idex), 64'(e.idex));
        chk("b.id_ex_bubble", 64'(b_bub), 64'(e.bub));
        chk("b.mem_error", 64'(b_me), 64'(e.me));
        chk("b.stall_count", 64'(b_sc), e.sc);
        chk("b.bubble_count", 64'(b_bc), e.bc);
        chk("b.flush_count", 64'(b_fc), e.fc);
      end
    end
  end

  initial begin
    int burst;
    reset = 1; rs1 = 0; rs2 = 0; u1 = 0; u2 = 0; exrd = 0;
    exw = 0; exsrc = 0; redir = 0; mreq = 0; mrdy = 0;
    for (int d = 0; d < 2; d++) begin
      err[d] = 0; streak[d] = 0; sc[d] = 0; bc[d] = 0; fc[d] = 0;
    end

    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(5);
    // load-use on rs2, then the same with rd = x0
    drive(0, 1, 5, 1, 1, 5, 1, 1, 0, 0, 0);
    idle(1);
    drive(0, 0, 0, 1, 1, 0, 1, 1, 0, 0, 0);
    drive(0, 7, 2, 1, 0, 7, 1, 1, 0, 0, 0);
    drive(0, 7, 2, 0, 1, 7, 1, 1, 0, 0, 0);
    drive(0, 7, 2, 1, 0, 7, 1, 0, 0, 0, 0);
    // redirect coincident with load-use
    drive(0, 3, 3, 1, 1, 3, 1, 1, 1, 0, 0);
    idle(1);
    // three wait cycles, then ready
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    idle(1);
    // redirect held through a freeze
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    // five redirects saturate the 2-bit counter
    for (int i = 0; i < 5; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    idle(1);
    // reset mid-run
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    idle(2);
    // watchdog: ready never arrives
    for (int i = 0; i < 8; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(3);
    drive(0, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(2);

    burst = 0;
    for (int i = 0; i < 2000; i++) begin
      bit rb, mq, mr;
      if (burst == 0 && $urandom_range(0, 39) == 0)
        burst = $urandom_range(1, 8);
      rb = ($urandom_range(0, 149) == 0);
      if (burst > 0) begin
        mq = 1; mr = 0; burst--;
      end else begin
        mq = ($urandom_range(0, 2) == 0);
        mr = ($urandom_range(0, 2) != 0);
      end
      drive(rb, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0),
            mq, mr);
    end

    for (int k = 0; k < 10 && (q0.size() + q1.size()) > 0; k++)
      @(negedge clk);
    #1;
    checks++;
    if (q0.size() + q1.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", q0.size() + q1.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_controller.md
# pipeline_hazard_controller

Central stall/flush controller for the 5-stage core. It drives the write enables of the PC register and the IF/ID and ID/EX pipeline registers, and the bubble/flush selects placed in front of them. It detects three conditions: load-use hazards, EX-stage redirects (taken branch/jump) and data-RAM wait states. Its sequential core is a memory-wait state machine with a timeout watchdog, plus saturating event counters read by the debug port.

## Interface
Parameters:
- MEM_TIMEOUT, 16: number of consecutive memory-stall cycles that trips the watchdog (legal range ≥ 2).
- COUNT_WIDTH, 32: width of each event counter.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- id_rs1_address  in  5  rs1 field of the instruction in ID.
- id_rs2_address  in  5  rs2 field of the instruction in ID.
- id_rs1_used  in  1  ID instruction reads rs1.
- id_rs2_used  in  1  ID instruction reads rs2.
- ex_rd_address  in  5  rd_address output of the ID/EX register.
- ex_reg_wren  in  1  reg_wren output of the ID/EX register.
- ex_reg_write_data_src  in  1  reg_write_data_src output of the ID/EX register; 1 = load (RAM data).
- ex_next_pc_src  in  1  1 = EX redirects the PC (taken branch/jump).
- mem_req  in  1  data-RAM access in progress this cycle.
- mem_ready  in  1  data RAM completes the access this cycle.
- pc_wren  out  1  PC register write enable.
- if_id_wren  out  1  IF/ID register write enable.
- if_id_flush  out  1  load NOP into IF/ID.
- id_ex_wren  out  1  ID/EX register wren.
- id_ex_bubble  out  1  zero all control inputs of ID/EX (reg_wren, ram_wren, next_pc_src, and so on) this cycle.
- mem_error  out  1  sticky watchdog flag.
- stall_count  out  COUNT_WIDTH  cycles frozen by memory wait.
- bubble_count  out  COUNT_WIDTH  load-use bubbles inserted.
- flush_count  out  COUNT_WIDTH  redirects serviced.

## Operation
- States: RUN, MEM_WAIT, ERROR. A 2-bit state register plus a wait counter of width clog2(MEM_TIMEOUT+1).
- Outputs are combinational from the state and the current inputs (Mealy); counters and state are registered.

Condition definitions:
- mem_stall = mem_req && !mem_ready.
- redirect = ex_next_pc_src.
- load_use = ex_reg_wren && ex_reg_write_data_src && ex_rd_address != 0 && ((id_rs1_used && id_rs1_address == ex_rd_address) || (id_rs2_used && id_rs2_address == ex_rd_address)).

Priority in RUN and MEM_WAIT: mem_stall > redirect > load_use > normal.
- Normal: pc_wren = if_id_wren = id_ex_wren = 1; flush = 0; bubble = 0.
- mem_stall (freeze): all three wren = 0; flush = 0; bubble = 0.
- redirect: pc_wren = 1 (target loads); if_id_wren = 1 with if_id_flush = 1; id_ex_wren = 1 with id_ex_bubble = 1. flush_count increments.
- load_use: pc_wren = 0 and if_id_wren = 0 (ID instruction held); id_ex_wren = 1 with id_ex_bubble = 1. bubble_count increments. On the following cycle the load has left EX, so the hazard clears.
- A redirect coincident with load_use is resolved as a redirect only. The dependent instruction is on the wrong path.

State transitions and the watchdog:
- RUN with mem_stall → MEM_WAIT, wait counter = 1.
- MEM_WAIT with mem_ready or !mem_req → RUN, wait counter = 0.
- MEM_WAIT with mem_stall continuing → wait counter increments.
- When a cycle is a stalled cycle and the wait counter already equals MEM_TIMEOUT−1 (i.e. it is the MEM_TIMEOUT-th consecutive stall), the next state is ERROR.
- ERROR: all wren = 0; flush = 0; bubble = 0; mem_error = 1. The block leaves ERROR only through reset.
- stall_count increments on every cycle frozen by mem_stall, in both RUN and MEM_WAIT.

Counters:
- All counters saturate at 2^COUNT_WIDTH−1.
- Counters never increment in ERROR or during reset.

## Timing
- Reset (reset = 1 at an edge): state = RUN, wait counter = 0, mem_error = 0, all counters = 0.
- While reset is high: pc_wren = if_id_wren = id_ex_wren = 0; if_id_flush = id_ex_bubble = 0.
- Zero-cycle latency: stall, flush and bubble outputs respond in the same cycle as the causing input.
- A load-use hazard costs exactly 1 cycle.
- A redirect costs 2 squashed instructions (the contents of IF/ID and ID/EX).
- A memory access with N wait cycles freezes the pipeline for N cycles. The pipeline advances on the cycle where mem_ready = 1.
- mem_req && mem_ready in the same cycle: no stall, state stays RUN.
- Redirect held during a memory freeze: it is not acted on until the freeze releases. EX is frozen, so ex_next_pc_src is still asserted when the freeze ends.
- Reset asserted in MEM_WAIT or ERROR: RUN at the next edge, wait counter and mem_error cleared.

## Test plan
- Reset, then 5 idle cycles → all wren = 1, flush = 0, bubble = 0, counters = 0; reset mid-run → counters return to 0 the next cycle.
- Load-use: ex rd = 5, load, ID rs2 = 5 used → one cycle with pc_wren = 0, if_id_wren = 0, id_ex_bubble = 1, bubble_count = 1. Repeat with ex rd = 0 → no bubble.
- Redirect with load_use simultaneously → if_id_flush = 1, id_ex_bubble = 1, pc_wren = 1, flush_count = 1, bubble_count unchanged.
- mem_req high, mem_ready low for 3 cycles then high → 3 frozen cycles, stall_count = 3, state back to RUN, pipeline advances on the 4th.
- MEM_TIMEOUT = 4, mem_ready held low → mem_error = 1 from the 5th cycle, all wren = 0 until reset, stall_count = 4.
- Counter saturation with COUNT_WIDTH = 2: 5 redirects → flush_count = 3.
